// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
//
// Up/down binary counter that also publishes the Gray encoding of its count
// and a one-cycle roll-over pulse. Binary, Gray and wrap are all registered on
// the same rising edge, so gray always equals encode(binary) with no lag and
// no input reaches an output combinationally.
//
// Parameters
//   WIDTH     counter / code width in bits (legal range 2..16)
//
// Ports
//   clk       single clock, rising-edge active
//   rst       synchronous, active-high reset (highest priority)
//   en        count enable: one step per cycle while high
//   up        direction: 1 = increment, 0 = decrement (applies this cycle)
//   load      synchronous load strobe (beats en, loses to rst)
//   load_bin  binary value captured on load
//   binary    registered count in plain binary
//   gray      registered Gray encoding of binary
//   wrap      registered pulse, high for one cycle after an enabled roll-over
// -----------------------------------------------------------------------------
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;

    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_gray;
    logic             next_wrap;

    // Next-state selection: load > en > hold. Reset is applied in the register
    // block so it overrides everything computed here.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        next_bin  = binary;
        next_wrap = 1'b0;

        if (load) begin
            next_bin = load_bin;
        end else if (en) begin
            if (up) begin
                next_bin  = binary + ONE;
                next_wrap = (binary == ALL_ONES);
            end else begin
                next_bin  = binary - ONE;
                next_wrap = (binary == ZERO);
            end
        end
    end

    // Encode the value about to be registered rather than the current one;
    // that keeps gray aligned with binary on the same edge.
    assign next_gray = next_bin ^ (next_bin >> 1);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values and simulation matches the synthesized logic.
        if (rst) begin
            binary <= ZERO;
            gray   <= ZERO;
            wrap   <= 1'b0;
        end else begin
            binary <= next_bin;
            gray   <= next_gray;
            wrap   <= next_wrap;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// -----------------------------------------------------------------------------
// tb_gray_counter
//
// Directed bench for gray_counter (WIDTH = 4). Each scenario task drives its
// stimulus and compares the registered outputs against hand-computed values.
// A background monitor checks the Gray relation on every cycle and the
// single-bit-change property on every enabled count step.
// -----------------------------------------------------------------------------
module tb_gray_counter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] binary;
    logic [WIDTH-1:0] gray;
    logic             wrap;

    int total;
    int bad;

    gray_counter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .binary   (binary),
        .gray     (gray),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- monitor
    logic             checking;
    logic             step_q;
    logic [WIDTH-1:0] prev_gray;

    // Remember whether the edge just taken was a plain enabled count step.
    always @(posedge clk) begin
        step_q <= en && !load && !rst;
    end

    always @(negedge clk) begin
        if (checking) begin
            total++;
            if (gray !== (binary ^ (binary >> 1))) begin
                bad++;
                $display("FAIL gray_relation: binary=%b gray=%b required gray=%b",
                         binary, gray, binary ^ (binary >> 1));
            end
            if (step_q) begin
                total++;
                if ($countones(gray ^ prev_gray) != 1) begin
                    bad++;
                    $display("FAIL gray_hamming: prev=%b now=%b distance=%0d required 1",
                             prev_gray, gray, $countones(gray ^ prev_gray));
                end
            end
        end
        prev_gray = gray;
    end

    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load = 1'b1; up = 1'b1; load_bin = 4'b1010;
        for (int i = 0; i < 2; i++) begin
            tick();
            checking = 1'b1;
            total++;
            if (binary !== 4'b0000 || gray !== 4'b0000 || wrap !== 1'b0) begin
                bad++;
                $display("FAIL reset_%0d: binary=%b gray=%b wrap=%b required 0000/0000/0",
                         i, binary, gray, wrap);
            end
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_count_up();
        logic [3:0] exp_gray [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                      4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                      4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                      4'b1010, 4'b1011, 4'b1001, 4'b1000};
        logic [3:0] eb;
        logic [3:0] eg;
        logic       ew;
        en = 1'b1; up = 1'b1;
        // 17 steps: through the full cycle, the wrap to 0000, and one more.
        for (int i = 1; i <= 17; i++) begin
            tick();
            eb = 4'(i % 16);
            eg = exp_gray[i % 16];
            ew = (i == 16);
            total++;
            if (binary !== eb || gray !== eg || wrap !== ew) begin
                bad++;
                $display("FAIL count_up_%0d: binary=%b gray=%b wrap=%b required %b/%b/%b",
                         i, binary, gray, wrap, eb, eg, ew);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_down_wrap();
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; up = 1'b0;
        tick();
        total++;
        if (binary !== 4'b1111 || gray !== 4'b1000 || wrap !== 1'b1) begin
            bad++;
            $display("FAIL down_wrap: binary=%b gray=%b wrap=%b required 1111/1000/1",
                     binary, gray, wrap);
        end
        tick();
        total++;
        if (binary !== 4'b1110 || gray !== 4'b1001 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL down_after_wrap: binary=%b gray=%b wrap=%b required 1110/1001/0",
                     binary, gray, wrap);
        end
        en = 1'b0;
    endtask

    task automatic test_load_priority();
        load = 1'b1; en = 1'b1; up = 1'b1; load_bin = 4'b0110;
        tick();
        total++;
        if (binary !== 4'b0110 || gray !== 4'b0101 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL load_priority: binary=%b gray=%b wrap=%b required 0110/0101/0",
                     binary, gray, wrap);
        end
        load = 1'b0;
        tick();
        total++;
        if (binary !== 4'b0111 || gray !== 4'b0100 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL step_after_load: binary=%b gray=%b wrap=%b required 0111/0100/0",
                     binary, gray, wrap);
        end
        // Direction flip takes effect on the same cycle.
        up = 1'b0;
        tick();
        total++;
        if (binary !== 4'b0110 || gray !== 4'b0101) begin
            bad++;
            $display("FAIL direction_flip: binary=%b gray=%b required 0110/0101",
                     binary, gray);
        end
        // Loading the current value changes nothing and never pulses wrap.
        en = 1'b0; load = 1'b1; load_bin = 4'b0110;
        tick();
        total++;
        if (binary !== 4'b0110 || gray !== 4'b0101 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL load_same: binary=%b gray=%b wrap=%b required 0110/0101/0",
                     binary, gray, wrap);
        end
        // Load to all-ones, then load zero: a load-driven "roll-over" is not a wrap.
        load_bin = 4'b1111;
        tick();
        load_bin = 4'b0000; en = 1'b1; up = 1'b1;
        tick();
        total++;
        if (binary !== 4'b0000 || gray !== 4'b0000 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL load_no_wrap: binary=%b gray=%b wrap=%b required 0000/0000/0",
                     binary, gray, wrap);
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_hold_and_reset();
        load = 1'b1; load_bin = 4'b0101;
        tick();
        load = 1'b0; en = 1'b0; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (binary !== 4'b0101 || gray !== 4'b0111 || wrap !== 1'b0) begin
                bad++;
                $display("FAIL hold_%0d: binary=%b gray=%b wrap=%b required 0101/0111/0",
                         i, binary, gray, wrap);
            end
        end
        rst = 1'b1; en = 1'b1;
        tick();
        total++;
        if (binary !== 4'b0000 || gray !== 4'b0000 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: binary=%b gray=%b wrap=%b required 0000/0000/0",
                     binary, gray, wrap);
        end
        rst = 1'b0;
        tick();
        total++;
        if (binary !== 4'b0001 || gray !== 4'b0001 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL step_after_reset: binary=%b gray=%b wrap=%b required 0001/0001/0",
                     binary, gray, wrap);
        end
        en = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; checking = 1'b0;
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_bin = '0;
        #2;
        test_reset();
        test_count_up();
        test_down_wrap();
        test_load_priority();
        test_hold_and_reset();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
